// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: accepts N-bit words over valid/ready and shifts
// them out one bit per clock with frame strobes and an optional inter-word gap.
module piso_serializer #(
    parameter int unsigned N         = 8,
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned GAP       = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         frame_start,
    output logic         last_bit,
    output logic         busy
);

    localparam int unsigned   CW       = $clog2(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
    localparam logic [7:0]    GAP_LAST = 8'((GAP > 0) ? GAP - 1 : 0);
    localparam bit            HAS_GAP  = (GAP != 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  sreg_q, sreg_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]    gap_cnt_q, gap_cnt_d;
    logic          sout_q, sout_d;
    logic          sout_valid_q, sout_valid_d;
    logic          frame_start_q, frame_start_d;
    logic          last_bit_q, last_bit_d;
    logic          busy_q, busy_d;
    logic          transfer_s;
    logic [N-1:0]  shifted_s;

    // Ready in IDLE, and on the last bit when streaming without a gap
    assign din_ready  = (state_q == ST_IDLE) ||
                        ((state_q == ST_SHIFT) && (bit_cnt_q == LAST_CNT) && !HAS_GAP);
    assign transfer_s = din_valid & din_ready;
    assign shifted_s  = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);

    // Next-state, shift register and counter update
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (transfer_s) begin
                    sreg_d    = din;
                    bit_cnt_d = {CW{1'b0}};
                    state_d   = ST_SHIFT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == LAST_CNT) begin
                    if (HAS_GAP) begin
                        sreg_d    = shifted_s;
                        gap_cnt_d = 8'd0;
                        state_d   = ST_GAP;
                    end else if (transfer_s) begin
                        sreg_d    = din;
                        bit_cnt_d = {CW{1'b0}};
                        state_d   = ST_SHIFT;
                    end else begin
                        sreg_d    = shifted_s;
                        bit_cnt_d = {CW{1'b0}};
                        state_d   = ST_IDLE;
                    end
                end else begin
                    sreg_d    = shifted_s;
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = 8'd0;
                    bit_cnt_d = {CW{1'b0}};
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                sreg_d    = {N{1'b0}};
                bit_cnt_d = {CW{1'b0}};
                gap_cnt_d = 8'd0;
            end
        endcase
    end

    // Outputs are derived from the next state so they appear registered
    always_comb begin
        sout_valid_d  = (state_d == ST_SHIFT);
        busy_d        = (state_d != ST_IDLE);
        frame_start_d = sout_valid_d && (bit_cnt_d == {CW{1'b0}});
        last_bit_d    = sout_valid_d && (bit_cnt_d == LAST_CNT);
        if (sout_valid_d) begin
            sout_d = LSB_FIRST ? sreg_d[0] : sreg_d[N-1];
        end else begin
            sout_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sreg_q        <= {N{1'b0}};
            bit_cnt_q     <= {CW{1'b0}};
            gap_cnt_q     <= 8'd0;
            sout_q        <= 1'b0;
            sout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            last_bit_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            sout_q        <= sout_d;
            sout_valid_q  <= sout_valid_d;
            frame_start_q <= frame_start_d;
            last_bit_q    <= last_bit_d;
            busy_q        <= busy_d;
        end
    end

    assign sout        = sout_q;
    assign sout_valid  = sout_valid_q;
    assign frame_start = frame_start_q;
    assign last_bit    = last_bit_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed vector table on two configurations plus
// random traffic checked against a queue-based output model and a loopback deserializer.
module tb_piso_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, dv0, rdy0, so0, sv0, fs0, lb0, bz0;
    logic [7:0] din0;
    logic       rst1, dv1, rdy1, so1, sv1, fs1, lb1, bz1;
    logic [7:0] din1;

    piso_serializer #(.N(8), .LSB_FIRST(1'b1), .GAP(0)) dut0 (
        .clk(clk), .rst(rst0), .din(din0), .din_valid(dv0), .din_ready(rdy0),
        .sout(so0), .sout_valid(sv0), .frame_start(fs0), .last_bit(lb0), .busy(bz0)
    );

    piso_serializer #(.N(8), .LSB_FIRST(1'b0), .GAP(1)) dut1 (
        .clk(clk), .rst(rst1), .din(din1), .din_valid(dv1), .din_ready(rdy1),
        .sout(so1), .sout_valid(sv1), .frame_start(fs1), .last_bit(lb1), .busy(bz1)
    );

    int checks   = 0;
    int failures = 0;
    int words0   = 0;

    // model: one entry {sout, sout_valid, frame_start, last_bit} per upcoming cycle
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic [7:0] wq0[$];
    logic [7:0] wq1[$];
    logic [7:0] des0 = 8'd0;
    logic [7:0] des1 = 8'd0;

    typedef struct {
        bit         sel;
        logic       rst;
        logic       vld;
        logic [7:0] din;
        logic [5:0] exp;   // {sout, sout_valid, frame_start, last_bit, busy, din_ready}
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%b expected=%b", name, idx, act, exp);
        end
    endtask

    function automatic logic [5:0] model_exp(input int d);
        int         sz;
        logic [3:0] f;
        bit         no_gap;
        sz     = (d == 0) ? q0.size() : q1.size();
        no_gap = (d == 0);
        if (sz == 0) return 6'b000001;
        f = (d == 0) ? q0[0] : q1[0];
        return {f, 1'b1, (no_gap && sz == 1)};
    endfunction

    task automatic push_word(input int d, input logic [7:0] w);
        logic [3:0] e;
        for (int i = 0; i < 8; i++) begin
            e = {((d == 0) ? w[i] : w[7-i]), 1'b1, (i == 0), (i == 7)};
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        if (d == 1) q1.push_back(4'b0000);
    endtask

    task automatic cycle(input logic r0, input logic v0, input logic [7:0] d0,
                         input logic r1, input logic v1, input logic [7:0] d1,
                         output logic [5:0] o0, output logic [5:0] o1);
        logic [5:0] e;
        logic       rm0, rm1;
        rst0 = r0; dv0 = v0; din0 = d0;
        rst1 = r1; dv1 = v1; din1 = d1;
        e = model_exp(0); rm0 = e[0];
        e = model_exp(1); rm1 = e[0];
        @(posedge clk);
        #1;
        if (r0) begin
            q0.delete(); wq0.delete();
        end else begin
            if (q0.size() > 0) void'(q0.pop_front());
            if (v0 && rm0) begin push_word(0, d0); wq0.push_back(d0); end
        end
        if (r1) begin
            q1.delete(); wq1.delete();
        end else begin
            if (q1.size() > 0) void'(q1.pop_front());
            if (v1 && rm1) begin push_word(1, d1); wq1.push_back(d1); end
        end
        o0 = {so0, sv0, fs0, lb0, bz0, rdy0};
        o1 = {so1, sv1, fs1, lb1, bz1, rdy1};
        check("model0", checks, {2'b00, o0}, {2'b00, model_exp(0)});
        check("model1", checks, {2'b00, o1}, {2'b00, model_exp(1)});
        if (sv0) des0 = {so0, des0[7:1]};
        if (sv1) des1 = {des1[6:0], so1};
        if (sv0 && lb0) begin
            words0++;
            if (wq0.size() > 0) check("loop0", words0, des0, wq0.pop_front());
            else check("loop0_noword", words0, 8'd1, 8'd0);
        end
        if (sv1 && lb1) begin
            if (wq1.size() > 0) check("loop1", checks, des1, wq1.pop_front());
            else check("loop1_noword", checks, 8'd1, 8'd0);
        end
    endtask

    task automatic add(input bit s, input logic r, input logic v, input logic [7:0] d, input logic [5:0] x);
        vec_t t;
        t.sel = s; t.rst = r; t.vld = v; t.din = d; t.exp = x;
        tbl.push_back(t);
    endtask

    initial begin
        logic [5:0] o0, o1;
        logic       r0, r1, v0, v1;
        logic [7:0] d0, d1;

        // dut0 (LSB first, no gap): reset, A5, 3C/F0 streaming, mid-word reset
        add(0, 1, 0, 8'h00, 6'b000001);
        add(0, 1, 0, 8'h00, 6'b000001);
        add(0, 1, 0, 8'h00, 6'b000001);
        add(0, 0, 0, 8'h00, 6'b000001);
        add(0, 0, 1, 8'hA5, 6'b111010);
        add(0, 0, 0, 8'h00, 6'b010010);
        add(0, 0, 0, 8'h00, 6'b110010);
        add(0, 0, 0, 8'h00, 6'b010010);
        add(0, 0, 0, 8'h00, 6'b010010);
        add(0, 0, 0, 8'h00, 6'b110010);
        add(0, 0, 0, 8'h00, 6'b010010);
        add(0, 0, 0, 8'h00, 6'b110111);
        add(0, 0, 0, 8'h00, 6'b000001);
        add(0, 0, 1, 8'h3C, 6'b011010);
        add(0, 0, 1, 8'hF0, 6'b010010);
        add(0, 0, 1, 8'hF0, 6'b110010);
        add(0, 0, 1, 8'hF0, 6'b110010);
        add(0, 0, 1, 8'hF0, 6'b110010);
        add(0, 0, 1, 8'hF0, 6'b110010);
        add(0, 0, 1, 8'hF0, 6'b010010);
        add(0, 0, 1, 8'hF0, 6'b010111);
        add(0, 0, 1, 8'hF0, 6'b011010);
        add(0, 0, 0, 8'h00, 6'b010010);
        add(0, 0, 0, 8'h00, 6'b010010);
        add(0, 0, 0, 8'h00, 6'b010010);
        add(0, 0, 0, 8'h00, 6'b110010);
        add(0, 0, 0, 8'h00, 6'b110010);
        add(0, 0, 0, 8'h00, 6'b110010);
        add(0, 0, 0, 8'h00, 6'b110111);
        add(0, 0, 0, 8'h00, 6'b000001);
        add(0, 0, 1, 8'hFF, 6'b111010);
        add(0, 0, 0, 8'h00, 6'b110010);
        add(0, 0, 0, 8'h00, 6'b110010);
        add(0, 1, 1, 8'hFF, 6'b000001);
        add(0, 0, 1, 8'h02, 6'b011010);
        add(0, 0, 0, 8'h00, 6'b110010);
        add(0, 0, 0, 8'h00, 6'b010010);
        add(0, 0, 0, 8'h00, 6'b010010);
        add(0, 0, 0, 8'h00, 6'b010010);
        add(0, 0, 0, 8'h00, 6'b010010);
        add(0, 0, 0, 8'h00, 6'b010010);
        add(0, 0, 0, 8'h00, 6'b010111);
        add(0, 0, 0, 8'h00, 6'b000001);
        // dut1 (MSB first, GAP=1): 81 then 7E with valid held, 10-cycle period
        add(1, 0, 1, 8'h81, 6'b111010);
        for (int i = 0; i < 6; i++) add(1, 0, 1, 8'h7E, 6'b010010);
        add(1, 0, 1, 8'h7E, 6'b110110);
        add(1, 0, 1, 8'h7E, 6'b000010);
        add(1, 0, 1, 8'h7E, 6'b000001);
        add(1, 0, 1, 8'h7E, 6'b011010);
        for (int i = 0; i < 6; i++) add(1, 0, 0, 8'h00, 6'b110010);
        add(1, 0, 0, 8'h00, 6'b010110);
        add(1, 0, 0, 8'h00, 6'b000010);
        add(1, 0, 0, 8'h00, 6'b000001);

        cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, o0, o1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, o0, o1);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].sel == 1'b0) begin
                cycle(tbl[i].rst, tbl[i].vld, tbl[i].din, 1'b0, 1'b0, 8'h00, o0, o1);
                check("tbl0", i, {2'b00, o0}, {2'b00, tbl[i].exp});
            end else begin
                cycle(1'b0, 1'b0, 8'h00, tbl[i].rst, tbl[i].vld, tbl[i].din, o0, o1);
                check("tbl1", i, {2'b00, o1}, {2'b00, tbl[i].exp});
            end
        end

        words0 = 0;
        for (int c = 0; c < 8000 && words0 < 256; c++) begin
            r0 = ($urandom_range(0, 99) == 0);
            r1 = ($urandom_range(0, 99) == 0);
            v0 = ($urandom_range(0, 9) < 8);
            v1 = ($urandom_range(0, 9) < 7);
            d0 = 8'($urandom_range(0, 255));
            d1 = 8'($urandom_range(0, 255));
            cycle(r0, v0, d0, r1, v1, d1, o0, o1);
        end
        check("loop_words_256", words0, {7'd0, (words0 >= 256)}, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out stage that sits directly upstream of the SIPO deserializer.
- Accepts N-bit words through a valid/ready handshake and drives one bit per clock on `sout`.
- Default bit order is LSB first, which matches a deserializer that shifts in at the MSB. After N shifts, word bit 0 lands at the deserializer's LSB.
- Provides framing strobes (`frame_start`, `last_bit`) and an optional inter-word idle gap, so the downstream bit counter stays aligned.

Parameters:
- N, 8, word width in bits (N >= 2).
- LSB_FIRST, 1, 1 = transmit din[0] first; 0 = transmit din[N-1] first.
- GAP, 0, number of idle cycles (sout_valid=0) inserted after each word (0..255).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- din  input  N  parallel word to serialize.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can accept din on this cycle.
- sout  output  1  serial data bit (registered).
- sout_valid  output  1  sout carries a valid data bit this cycle.
- frame_start  output  1  high while the first bit of a word is on sout.
- last_bit  output  1  high while the final bit of a word is on sout.
- busy  output  1  high in SHIFT or GAP state.

Behaviour:
- Reset: one clock and reset are fixed. Synchronous active-high rst at a clk edge forces the following:
  - state = IDLE, shift register = 0, bit_cnt = 0, gap_cnt = 0.
  - sout = 0, sout_valid = 0, frame_start = 0, last_bit = 0, busy = 0.
  - din_ready = 1 in the cycle after reset.
  - Reset mid-word aborts the word with no further bits emitted. A word offered in the same cycle as rst is not accepted.
- States:
  - IDLE: din_ready=1, sout_valid=0, sout=0.
  - SHIFT: emits N bits, bit_cnt runs 0..N-1.
  - GAP: emits GAP idle cycles, gap_cnt runs 0..GAP-1, din_ready=0.
- Handshake: a transfer occurs at a clk edge where din_valid & din_ready.
  - On transfer, din is captured into the shift register, bit_cnt is set to 0, and the state goes to SHIFT.
  - din is ignored in any cycle without a transfer. din_valid may stay high while din_ready=0 with no side effect.
- din_ready is combinational. It is 1 in IDLE, and also in SHIFT when bit_cnt==N-1 and GAP==0 (back-to-back streaming, no bubble).
- Latency: for a transfer at edge k, bit 0 of the word is on sout from edge k to edge k+1. Each bit holds exactly one cycle. Word bits occupy cycles k..k+N-1.
- Bit order:
  - With LSB_FIRST=1, sout = sreg[0] and the register shifts right each cycle.
  - With LSB_FIRST=0, sout = sreg[N-1] and the register shifts left.
- Strobes:
  - sout_valid = 1 exactly in SHIFT.
  - frame_start = sout_valid & (bit_cnt==0).
  - last_bit = sout_valid & (bit_cnt==N-1).
  - busy = (state != IDLE).
- End of word (SHIFT, bit_cnt==N-1):
  - If GAP>0, go to GAP.
  - Else, if a transfer occurs, reload and stay in SHIFT.
  - Else, go to IDLE.
- GAP: after GAP cycles, go to IDLE. The next word can transfer in that IDLE cycle at the earliest. Word period with continuous din_valid is therefore N+GAP+1 cycles for GAP>0, and N cycles for GAP=0.
- No internal buffering beyond the single shift register. Backpressure to the producer is via din_ready only.

Test Plan:
- Reset idle check: N=8, LSB_FIRST=1, GAP=0; hold rst high 3 cycles then release → all outputs 0, din_ready=1, sout_valid=0 until the first transfer.
- Single word A5: din=8'hA5 with a one-cycle din_valid → sout = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting the cycle after accept. frame_start on cycle 1, last_bit on cycle 8, then IDLE.
- Back-to-back streaming: din_valid held with words 3C then F0 → 16 contiguous sout_valid cycles with bits 0,0,1,1,1,1,0,0 followed by 0,0,0,0,1,1,1,1. din_ready high only in IDLE and on each last_bit cycle; no bubble between words.
- Inter-word gap: GAP=1, LSB_FIRST=0; din=8'h81 then 8'h7E with valid held → first word sends 1,0,0,0,0,0,0,1, then 1 gap cycle plus 1 IDLE cycle, then 0,1,1,1,1,1,1,0. Period is 10 cycles.
- Mid-word reset: assert rst after 3 bits of 8'hFF → sout_valid=0 and sout=0 the cycle after, no remaining bits emitted. The next word after reset serializes cleanly from bit 0.
- Loopback: connect sout into the SIPO deserializer (N=8) and feed 256 random words → every word reconstructed exactly at each last_bit+1 boundary.
